// File: rtl/alu_pkg.sv
// alu_pkg -- opcode constants and shared types for the sequential ALU.
//
// Shared between the ALU control unit (which produces aluoperation) and
// seq_alu (which executes it).  Codes above ALU_MUL are unsupported, and
// ALU_ILLEGAL is the canonical unsupported code.
package alu_pkg;

  localparam logic [3:0] ALU_ADD     = 4'b0000;
  localparam logic [3:0] ALU_SUB     = 4'b0001;
  localparam logic [3:0] ALU_XOR     = 4'b0010;
  localparam logic [3:0] ALU_OR      = 4'b0011;
  localparam logic [3:0] ALU_AND     = 4'b0100;
  localparam logic [3:0] ALU_SLLI    = 4'b0101;
  localparam logic [3:0] ALU_SRLI    = 4'b0110;
  localparam logic [3:0] ALU_SLL     = 4'b0111;
  localparam logic [3:0] ALU_SRL     = 4'b1000;
  localparam logic [3:0] ALU_SLT     = 4'b1001;
  localparam logic [3:0] ALU_MUL     = 4'b1010;
  localparam logic [3:0] ALU_ILLEGAL = 4'b1111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    FIN  = 2'd2
  } seq_alu_state_e;

  // Supported codes are contiguous from ALU_ADD to ALU_MUL.
  function automatic logic alu_op_legal(input logic [3:0] op);
    return (op <= ALU_MUL);
  endfunction

endpackage

// File: rtl/seq_alu_mul.sv
// seq_alu_mul -- iterative shift-add multiplier, one partial product per clock.
//
// Ports:
//   clk, reset      : clock and synchronous active-high reset
//   start           : load operands a/b and begin DATA_WIDTH iterations
//   a, b            : multiplicand / multiplier (captured on start)
//   done            : high during the clock whose rising edge performs the
//                     last iteration; product is valid in that same cycle
//   product         : low DATA_WIDTH bits of a*b (combinational view of the
//                     accumulator after the current iteration)
module seq_alu_mul
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] product
);

  localparam int CNT_W = $clog2(DATA_WIDTH);

  logic                  run_p0;
  logic [CNT_W-1:0]      cnt_p0;
  logic [DATA_WIDTH-1:0] acc_p0;
  logic [DATA_WIDTH-1:0] mcand_p0;
  logic [DATA_WIDTH-1:0] mplier_p0;
  logic [DATA_WIDTH-1:0] acc_nxt;

  // Partial product for the current multiplier bit; bits shifted past the
  // top of mcand drop out, which gives the modulo-2^DATA_WIDTH wrap.
  always_comb begin
    acc_nxt = acc_p0;
    if (mplier_p0[0]) acc_nxt = acc_p0 + mcand_p0;
  end

  assign done    = run_p0 && (cnt_p0 == CNT_W'(DATA_WIDTH - 1));
  assign product = acc_nxt;

  // ---- control: iteration counter, cleared by reset (aborts a multiply)
  always_ff @(posedge clk) begin
    if (reset) begin
      run_p0 <= 1'b0;
      cnt_p0 <= '0;
    end else if (start) begin
      run_p0 <= 1'b1;
      cnt_p0 <= '0;
    end else if (run_p0) begin
      cnt_p0 <= cnt_p0 + 1'b1;
      if (done) run_p0 <= 1'b0;
    end
  end

  // ---- datapath: operands and accumulator, not reset
  always_ff @(posedge clk) begin
    if (start) begin
      acc_p0    <= '0;
      mcand_p0  <= a;
      mplier_p0 <= b;
    end else if (run_p0) begin
      acc_p0    <= acc_nxt;
      mcand_p0  <= mcand_p0 << 1;
      mplier_p0 <= mplier_p0 >> 1;
    end
  end

endmodule

// File: rtl/seq_alu.sv
// seq_alu -- sequential RV-style ALU with single-cycle ops and an iterative
// multiplier.
//
// Ports:
//   clk, reset    : clock, synchronous active-high reset (wins over start)
//   start         : request one operation; accepted only while busy=0
//   aluoperation  : 4-bit opcode from alu_pkg
//   a, b          : operands; b[log2(DATA_WIDTH)-1:0] is the shift amount
//   busy          : multiply in progress, start ignored
//   done          : one-cycle pulse, result/zero/illegal valid
//   result, zero, illegal : registered, held until the next completion
//
// Build option: define SEQ_ALU_FAST_MUL_EN to compute mul in a single cycle
// (no MUL state, busy never asserted).  Default build uses seq_alu_mul.
module seq_alu
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [3:0]            aluoperation,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  zero,
  output logic                  illegal
);

  localparam int SHW = $clog2(DATA_WIDTH);

  seq_alu_state_e        state, state_nxt;
  logic                  accept;
  logic                  start_is_mul;
  logic                  mul_start;
  logic                  mul_done;
  logic [DATA_WIDTH-1:0] mul_product;
  logic [DATA_WIDTH-1:0] alu_p0;
  logic                  legal_p0;

  logic                  vld_p1;
  logic [DATA_WIDTH-1:0] result_p1;
  logic                  zero_p1;
  logic                  illegal_p1;

  function automatic logic [DATA_WIDTH-1:0] alu_eval(
    input logic [3:0]            op,
    input logic [DATA_WIDTH-1:0] x,
    input logic [DATA_WIDTH-1:0] y
  );
    logic signed [DATA_WIDTH-1:0] xs;
    logic signed [DATA_WIDTH-1:0] ys;
    logic        [SHW-1:0]        sh;
    logic        [DATA_WIDTH-1:0] r;
    xs = x;
    ys = y;
    sh = y[SHW-1:0];
    case (op)
      ALU_ADD:           r = x + y;
      ALU_SUB:           r = x - y;
      ALU_XOR:           r = x ^ y;
      ALU_OR:            r = x | y;
      ALU_AND:           r = x & y;
      ALU_SLLI, ALU_SLL: r = x << sh;
      ALU_SRLI, ALU_SRL: r = x >> sh;
      ALU_SLT:           r = {{(DATA_WIDTH-1){1'b0}}, (xs < ys)};
`ifdef SEQ_ALU_FAST_MUL_EN
      ALU_MUL:           r = x * y;
`endif
      // Illegal codes (and mul on the iterative build, handled elsewhere)
      default:           r = '0;
    endcase
    return r;
  endfunction

  assign busy         = (state == MUL);
  assign accept       = start && !busy;
  assign alu_p0       = alu_eval(aluoperation, a, b);
  assign legal_p0     = alu_op_legal(aluoperation);

`ifdef SEQ_ALU_FAST_MUL_EN
  assign start_is_mul = 1'b0;
  assign mul_start    = 1'b0;
  assign mul_done     = 1'b0;
  assign mul_product  = '0;
`else
  assign start_is_mul = (aluoperation == ALU_MUL);
  assign mul_start    = accept && start_is_mul;

  seq_alu_mul #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_mul (
    .clk     (clk),
    .reset   (reset),
    .start   (mul_start),
    .a       (a),
    .b       (b),
    .done    (mul_done),
    .product (mul_product)
  );
`endif

  // FIN behaves like IDLE for accepting work, which gives back-to-back issue
  // in the cycle where done is high.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, FIN: begin
        state_nxt = IDLE;
        if (accept && start_is_mul) state_nxt = MUL;
      end
      MUL:       if (mul_done) state_nxt = FIN;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // ---- p1: registered outputs; single-cycle ops land on the accepting
  // edge, multiplies on the edge of their last iteration
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1     <= 1'b0;
      result_p1  <= '0;
      zero_p1    <= 1'b1;
      illegal_p1 <= 1'b0;
    end else begin
      vld_p1 <= 1'b0;
      if (accept && !start_is_mul) begin
        vld_p1     <= 1'b1;
        result_p1  <= alu_p0;
        zero_p1    <= (alu_p0 == '0);
        illegal_p1 <= !legal_p0;
      end else if ((state == MUL) && mul_done) begin
        vld_p1     <= 1'b1;
        result_p1  <= mul_product;
        zero_p1    <= (mul_product == '0);
        illegal_p1 <= 1'b0;
      end
    end
  end

  assign done    = vld_p1;
  assign result  = result_p1;
  assign zero    = zero_p1;
  assign illegal = illegal_p1;

endmodule

// File: tb/tb_seq_alu.sv
module tb_seq_alu;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  aluoperation;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        zero;
  logic        illegal;

  int n_assert = 0;
  int n_fail   = 0;
  bit saw_done;

  seq_alu #(.DATA_WIDTH(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .aluoperation (aluoperation),
    .a            (a),
    .b            (b),
    .busy         (busy),
    .done         (done),
    .result       (result),
    .zero         (zero),
    .illegal      (illegal)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
    start        = 1'b1;
    aluoperation = op;
    a            = x;
    b            = y;
  endtask

  // Issue one op, step past the accepting edge, drop start.
  task automatic issue(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
    drive(op, x, y);
    tick();
    start = 1'b0;
    a     = 32'hDEAD_BEEF;
    b     = 32'h0BAD_F00D;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; aluoperation = ALU_ADD; a = '0; b = '0;
    #1;
    tick(); tick();
    chk("rst_busy",    {31'd0, busy},    32'd0);
    chk("rst_done",    {31'd0, done},    32'd0);
    chk("rst_result",  result,           32'd0);
    chk("rst_zero",    {31'd0, zero},    32'd1);
    chk("rst_illegal", {31'd0, illegal}, 32'd0);
    reset = 1'b0;
    tick();

    issue(ALU_SUB, 32'd5, 32'd7);
    chk("sub_done",   {31'd0, done}, 32'd1);
    chk("sub_result", result,        32'hFFFF_FFFE);
    chk("sub_zero",   {31'd0, zero}, 32'd0);
    tick();
    chk("sub_done_pulse", {31'd0, done}, 32'd0);
    chk("sub_hold",       result,        32'hFFFF_FFFE);

    issue(ALU_SLT, 32'hFFFF_FFFF, 32'd1);
    chk("slt_result", result, 32'd1);
    issue(ALU_SLL, 32'd1, 32'h25);
    chk("sll_result", result, 32'h20);
    issue(ALU_SRL, 32'h8000_0000, 32'd31);
    chk("srl_logical", result, 32'd1);
    issue(ALU_XOR, 32'hF0F0_00FF, 32'h0FF0_0F0F);
    chk("xor_result", result, 32'hFF00_0FF0);
    issue(ALU_ADD, 32'hFFFF_FFFF, 32'd1);
    chk("add_wrap", result,        32'd0);
    chk("add_zero", {31'd0, zero}, 32'd1);

    // Multiply, with stray starts during busy that must be ignored.
    issue(ALU_MUL, 32'h0001_0000, 32'h0001_0001);
    for (int i = 1; i <= 32; i++) begin
      chk($sformatf("mul_busy_c%0d", i), {30'd0, busy, done}, 32'd2);
      if (i >= 3 && i <= 6) drive(ALU_ADD, 32'd1, 32'd1);
      else start = 1'b0;
      tick();
    end
    chk("mul_done",   {30'd0, busy, done}, 32'd1);
    chk("mul_result", result,              32'h0001_0000);
    // Back-to-back add in the done cycle.
    issue(ALU_ADD, 32'd3, 32'd4);
    chk("b2b_done",   {30'd0, busy, done}, 32'd1);
    chk("b2b_result", result,              32'd7);
    tick();
    chk("b2b_hold",   {31'd0, done}, 32'd0);
    chk("b2b_hold_r", result,        32'd7);

    issue(ALU_ILLEGAL, 32'd5, 32'd5);
    chk("ill_done",    {31'd0, done},    32'd1);
    chk("ill_result",  result,           32'd0);
    chk("ill_zero",    {31'd0, zero},    32'd1);
    chk("ill_flag",    {31'd0, illegal}, 32'd1);
    tick();
    chk("ill_hold",    {31'd0, illegal}, 32'd1);
    issue(ALU_ADD, 32'd2, 32'd2);
    chk("ill_clear",   {31'd0, illegal}, 32'd0);
    chk("ill_clear_r", result,           32'd4);
    issue(4'b1011, 32'd1, 32'd1);
    chk("ill_1011",    {31'd0, illegal}, 32'd1);

    // Reset in cycle 10 of a multiply.
    issue(ALU_MUL, 32'd3, 32'd5);
    for (int i = 1; i < 10; i++) tick();
    chk("abort_pre_busy", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_busy",    {31'd0, busy},    32'd0);
    chk("abort_done",    {31'd0, done},    32'd0);
    chk("abort_result",  result,           32'd0);
    chk("abort_zero",    {31'd0, zero},    32'd1);
    chk("abort_illegal", {31'd0, illegal}, 32'd0);
    saw_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done || busy) saw_done = 1'b1;
      tick();
    end
    chk("abort_no_done", {31'd0, saw_done}, 32'd0);

    // Reset wins over a simultaneous start.
    drive(ALU_ADD, 32'd1, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    start = 1'b0;
    chk("rst_prio_done",   {31'd0, done}, 32'd0);
    chk("rst_prio_result", result,        32'd0);
    tick();
    chk("rst_prio_after",  {31'd0, done}, 32'd0);

    // Full multiply after the abort to confirm the multiplier recovers.
    issue(ALU_MUL, 32'd12345, 32'd6789);
    for (int i = 1; i <= 32; i++) tick();
    chk("mul2_done",   {31'd0, done}, 32'd1);
    chk("mul2_result", result,        32'd83810205);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, operand/result width (must be at least 8).
REQ-002 SHALL have port clk  input  1  single clock, all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request to execute one operation.
REQ-005 SHALL have port aluoperation  input  4  operation code produced by ALU control.
REQ-006 SHALL have port a  input  DATA_WIDTH  operand A (rs1 or PC).
REQ-007 SHALL have port b  input  DATA_WIDTH  operand B (rs2 or immediate).
REQ-008 SHALL have port busy  output  1  operation in progress; start ignored.
REQ-009 SHALL have port done  output  1  one-cycle pulse; result, zero and illegal are valid.
REQ-010 SHALL have port result  output  DATA_WIDTH  registered operation result.
REQ-011 SHALL have port zero  output  1  registered (result == 0).
REQ-012 SHALL have port illegal  output  1  registered flag for an unsupported code.

Function
REQ-013 SHALL decode codes: 0000 add, 0001 sub, 0010 xor, 0011 or, 0100 and, 0101 slli, 0110 srli, 0111 sll, 1000 srl, 1001 slt, 1010 mul; all others illegal.
REQ-014 SHALL implement FSM states IDLE, MUL, FIN; reset state IDLE.
REQ-015 SHALL accept start only when busy=0, capturing a, b and aluoperation on the accepting edge; inputs may change afterward.
REQ-016 SHALL, for non-mul codes, register result on the accepting edge and assert done in the following cycle (latency 1), remaining in IDLE.
REQ-017 SHALL, for mul, enter MUL with busy=1, run one shift-add iteration per clock for DATA_WIDTH clocks, then enter FIN, register the product, assert done and return to IDLE (latency DATA_WIDTH+1).
REQ-018 SHALL wrap add/sub/mul modulo 2^DATA_WIDTH; mul returns the low DATA_WIDTH bits.
REQ-019 SHALL use b[log2(DATA_WIDTH)-1:0] as the shift amount; srl/srli are logical.
REQ-020 SHALL compute slt as signed two's-complement compare, result 1 or 0 zero-extended.
REQ-021 SHALL, for illegal codes, set result=0, illegal=1 and pulse done with latency 1; illegal clears on the next accepted operation.
REQ-022 SHALL hold result, zero and illegal stable from done until the next completion.
REQ-023 SHALL accept a new start in the same cycle that done=1 (back-to-back issue).
REQ-024 SHALL ignore start while busy=1, with no effect on the operation in progress.

Reset
REQ-025 SHALL, on reset, drive busy=0, done=0, result=0, zero=1, illegal=0, state IDLE.
REQ-026 SHALL abort any in-progress mul on reset and produce no done pulse for it.
REQ-027 SHALL give reset priority over start when both are asserted on the same edge.

Configuration
REQ-028 SHALL honour macro SEQ_ALU_FAST_MUL_EN: when defined, mul completes in one cycle (latency 1, no MUL state, busy never 1); when undefined, the iterative path of REQ-017 is used.

Structure
REQ-029 SHALL take the opcode constants (ALU_ADD ... ALU_MUL, ALU_ILLEGAL=4'b1111) from shared package alu_pkg, also used by the ALU control unit.
REQ-030 SHALL place the iterative multiplier in sub-module seq_alu_mul (start, operands, done, product).

Verification
REQ-031 Bench SHALL check: sub a=5, b=7 -> one cycle later done=1, result=32'hFFFFFFFE, zero=0.
REQ-032 Bench SHALL check: slt a=32'hFFFFFFFF, b=1 -> result=1; sll a=1, b=32'h25 -> result=32'h20.
REQ-033 Bench SHALL check: mul a=32'h10000, b=32'h10001 -> busy for 32 cycles, done at cycle 33, result=32'h10000; start pulses during busy ignored.
REQ-034 Bench SHALL check: code 4'b1111 -> done after 1 cycle, result=0, zero=1, illegal=1; next add clears illegal.
REQ-035 Bench SHALL check: reset asserted at cycle 10 of a mul -> busy=0 next cycle, no done pulse, outputs at reset values.
REQ-036 Bench SHALL check: add issued in the same cycle as a mul's done -> accepted, done one cycle later with the correct sum.
